router_reg_param: RTL and testbench

- Parametrised packet register stage for the router datapath. It sits between the router FSM and the destination FIFOs.
- Latches the header and tracks a running check value in one of two modes (XOR parity or additive checksum). It also checks payload length against the header.
- Bytes that arrive while the destination FIFO is full are buffered in a HOLD_DEPTH-entry hold queue instead of a single byte.
- Raises check-error and length-error flags when the FSM asserts rst_int_reg.

---
 rtl/router_reg_param_if.sv | 20 ++
 rtl/router_reg_param.sv | 141 ++++++++++++++
 tb/tb_router_reg_param.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/router_reg_param_if.sv
// Byte bus between the router source, this register stage and the FIFO.
// master: drives pkt_valid/data_in/fifo_full; slave: drives data_out.
interface router_reg_param_if #(
   parameter int DATA_W = 8
) ();
   logic              pkt_valid;
   logic [DATA_W-1:0] data_in;
   logic              fifo_full;
   logic [DATA_W-1:0] data_out;

   modport master (
      output pkt_valid, data_in, fifo_full,
      input  data_out
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full,
      output data_out
   );
endinterface

// File: rtl/router_reg_param.sv
// Router packet register stage: header latch, running check (XOR/sum),
// payload length check and a HOLD_DEPTH-entry hold queue for stalled bytes.
// Ports: clk, rst (sync, active-high); bus (pkt_valid, data_in, fifo_full
// in, data_out out); FSM strobes detect_addr, lfd_state, ld_state,
// laf_state, full_state, rst_int_reg; status parity_done, low_pkt_valid,
// err, len_err, hold_empty, hold_ovf.
module router_reg_param #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 2,
   parameter int NUM_DEST   = 3,
   parameter int CHK_MODE   = 0,
   parameter int HOLD_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   router_reg_param_if.slave   bus,
   input  logic                detect_addr,
   input  logic                lfd_state,
   input  logic                ld_state,
   input  logic                laf_state,
   input  logic                full_state,
   input  logic                rst_int_reg,
   output logic                parity_done,
   output logic                low_pkt_valid,
   output logic                err,
   output logic                len_err,
   output logic                hold_empty,
   output logic                hold_ovf
);
   localparam int CNT_W = DATA_W - ADDR_W;
   localparam int PW    = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
   localparam int CW    = $clog2(HOLD_DEPTH + 1);
   localparam logic [ADDR_W:0] NDEST = (ADDR_W+1)'(NUM_DEST);

   logic [DATA_W-1:0] header, chk, chk_byte, head, dout_nxt;
   logic [CNT_W-1:0]  pay_cnt, hdr_len;
   logic [DATA_W-1:0] mem [HOLD_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic hdr_ok, ld_byte, q_full;
   logic sel_hdr, sel_laf, sel_ldq, sel_ldp;
   logic pop, push, push_ok, drop, pd_set;

   function automatic logic [DATA_W-1:0] f(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      if (CHK_MODE == 1) return a + b;
      else               return a ^ b;
   endfunction

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(HOLD_DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign hdr_len = header[DATA_W-1:ADDR_W];
   assign head    = mem[rd_ptr];

   always_comb begin
      hdr_ok  = detect_addr & bus.pkt_valid &
                ({1'b0, bus.data_in[ADDR_W-1:0]} < NDEST);
      ld_byte = ld_state & bus.pkt_valid & !full_state;
      // Output selects are masked down to one-hot in priority order.
      sel_hdr = !hdr_ok & lfd_state;
      sel_laf = !hdr_ok & !lfd_state & laf_state &
                !bus.fifo_full & !hold_empty;
      sel_ldq = !hdr_ok & !lfd_state & !sel_laf & ld_state &
                !bus.fifo_full & !hold_empty;
      sel_ldp = !hdr_ok & !lfd_state & !sel_laf & ld_state &
                !bus.fifo_full & hold_empty;
      pop     = sel_laf | sel_ldq;
      // While draining, new bytes queue behind the head to keep order.
      push    = ld_state & bus.pkt_valid & (bus.fifo_full | sel_ldq);
      q_full  = (cnt == CW'(HOLD_DEPTH));
      push_ok = push & (!q_full | pop);
      drop    = push & q_full & !pop;
      cnt_nxt = cnt;
      if (push_ok & !pop)      cnt_nxt = cnt + 1'b1;
      else if (pop & !push_ok) cnt_nxt = cnt - 1'b1;
      pd_set  = (ld_state & !bus.fifo_full & !bus.pkt_valid & hold_empty) |
                (laf_state & low_pkt_valid & !parity_done &
                 ((cnt == '0) | ((cnt == CW'(1)) & pop)));
      dout_nxt = bus.data_out;
      unique case (1'b1)
         sel_hdr:          dout_nxt = header;
         sel_laf, sel_ldq: dout_nxt = head;
         sel_ldp:          dout_nxt = bus.data_in;
         default:          dout_nxt = bus.data_out;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= bus.data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         header        <= '0;
         chk           <= '0;
         chk_byte      <= '0;
         pay_cnt       <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         cnt           <= '0;
         bus.data_out  <= '0;
         parity_done   <= 1'b0;
         low_pkt_valid <= 1'b0;
         err           <= 1'b0;
         len_err       <= 1'b0;
         hold_empty    <= 1'b1;
         hold_ovf      <= 1'b0;
      end else begin
         if (hdr_ok) header <= bus.data_in;
         if (detect_addr) begin
            chk         <= '0;
            chk_byte    <= '0;
            pay_cnt     <= '0;
            parity_done <= 1'b0;
            hold_ovf    <= 1'b0;
         end else begin
            if (lfd_state)    chk <= f(chk, header);
            else if (ld_byte) chk <= f(chk, bus.data_in);
            if (ld_byte && !(&pay_cnt)) pay_cnt <= pay_cnt + 1'b1;
            if (ld_state && !bus.pkt_valid) chk_byte <= bus.data_in;
            if (pd_set) parity_done <= 1'b1;
            if (drop)   hold_ovf    <= 1'b1;
         end
         if (rst_int_reg) low_pkt_valid <= 1'b0;
         else if (ld_state && !bus.pkt_valid) low_pkt_valid <= 1'b1;
         if (rst_int_reg) begin
            err     <= (chk_byte != chk);
            len_err <= (pay_cnt != hdr_len);
         end
         if (push_ok) wr_ptr <= inc(wr_ptr);
         if (pop)     rd_ptr <= inc(rd_ptr);
         cnt          <= cnt_nxt;
         hold_empty   <= (cnt_nxt == '0);
         bus.data_out <= dout_nxt;
      end
   end
endmodule

// File: tb/tb_router_reg_param.sv
// Bench for router_reg_param: XOR and sum instances driven in parallel,
// checked against a packet-level model built on an SV queue.
module tb_router_reg_param;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, det, lfd, ld, laf, fst, rint, pv, ff;
   logic [7:0] din;
   logic pd0, lpv0, e0, le0, he0, ov0;
   logic pd1, lpv1, e1, le1, he1, ov1;

   router_reg_param_if #(.DATA_W(8)) if0 ();
   router_reg_param_if #(.DATA_W(8)) if1 ();
   assign if0.pkt_valid = pv;
   assign if0.data_in   = din;
   assign if0.fifo_full = ff;
   assign if1.pkt_valid = pv;
   assign if1.data_in   = din;
   assign if1.fifo_full = ff;

   router_reg_param #(.CHK_MODE(0)) u0 (
      .clk(clk), .rst(rst), .bus(if0),
      .detect_addr(det), .lfd_state(lfd), .ld_state(ld),
      .laf_state(laf), .full_state(fst), .rst_int_reg(rint),
      .parity_done(pd0), .low_pkt_valid(lpv0), .err(e0),
      .len_err(le0), .hold_empty(he0), .hold_ovf(ov0)
   );
   router_reg_param #(.CHK_MODE(1)) u1 (
      .clk(clk), .rst(rst), .bus(if1),
      .detect_addr(det), .lfd_state(lfd), .ld_state(ld),
      .laf_state(laf), .full_state(fst), .rst_int_reg(rint),
      .parity_done(pd1), .low_pkt_valid(lpv1), .err(e1),
      .len_err(le1), .hold_empty(he1), .hold_ovf(ov1)
   );

   int checks = 0;
   int errors = 0;
   string tname = "init";

   logic [7:0] q[$];
   logic [7:0] dout_m, hdr_m;
   logic pd_m, lpv_m, ovf_m, e0_m, e1_m, le_m;
   logic [7:0] pay_b [16];
   logic       ff_b  [16];

   task automatic cmp8(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmp1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic tick(input string tag);
      string t;
      @(posedge clk);
      #1;
      t = {tname, ".", tag};
      cmp8({t, ".dout0"}, if0.data_out, dout_m);
      cmp8({t, ".dout1"}, if1.data_out, dout_m);
      cmp1({t, ".hold_empty0"}, he0, q.size() == 0);
      cmp1({t, ".hold_empty1"}, he1, q.size() == 0);
      cmp1({t, ".hold_ovf0"}, ov0, ovf_m);
      cmp1({t, ".hold_ovf1"}, ov1, ovf_m);
      cmp1({t, ".parity_done0"}, pd0, pd_m);
      cmp1({t, ".parity_done1"}, pd1, pd_m);
      cmp1({t, ".low_pkt_valid0"}, lpv0, lpv_m);
      cmp1({t, ".low_pkt_valid1"}, lpv1, lpv_m);
      cmp1({t, ".err0"}, e0, e0_m);
      cmp1({t, ".err1"}, e1, e1_m);
      cmp1({t, ".len_err0"}, le0, le_m);
      cmp1({t, ".len_err1"}, le1, le_m);
   endtask

   task automatic clr_in();
      det = 0; lfd = 0; ld = 0; laf = 0; fst = 0; rint = 0;
      pv = 0; ff = 0; din = '0;
   endtask

   task automatic model_reset();
      q.delete();
      dout_m = '0; hdr_m = '0;
      pd_m = 0; lpv_m = 0; ovf_m = 0;
      e0_m = 0; e1_m = 0; le_m = 0;
   endtask

   task automatic do_reset();
      clr_in();
      rst = 1;
      model_reset();
      tick("rst");
      rst = 0;
   endtask

   task automatic det_step(input logic [7:0] hdr);
      clr_in();
      det = 1; pv = 1; din = hdr;
      if (hdr[1:0] < 2'd3) hdr_m = hdr;
      ovf_m = 0; pd_m = 0;
      tick("det");
   endtask

   task automatic lfd_step();
      clr_in();
      lfd = 1; pv = 1; din = pay_b[0];
      dout_m = hdr_m;
      tick("lfd");
   endtask

   task automatic ld_step(input logic [7:0] b, input logic f);
      clr_in();
      ld = 1; pv = 1; din = b; ff = f;
      if (f) begin
         if (q.size() < 4) q.push_back(b);
         else ovf_m = 1;
      end else if (q.size() > 0) begin
         dout_m = q.pop_front();
         q.push_back(b);
      end else begin
         dout_m = b;
      end
      tick("ld");
   endtask

   task automatic send_pkt(input logic [7:0] hdr, input int n,
                           input logic [7:0] cb, input logic ffc);
      logic [7:0] c0, c1;
      int lenv;
      c0 = hdr; c1 = hdr;
      for (int i = 0; i < n; i++) begin
         c0 = c0 ^ pay_b[i];
         c1 = c1 + pay_b[i];
      end
      det_step(hdr);
      lfd_step();
      for (int i = 0; i < n; i++) ld_step(pay_b[i], ff_b[i]);
      clr_in();
      ld = 1; pv = 0; din = cb; ff = ffc;
      lpv_m = 1;
      if (!ffc) begin
         if (q.size() == 0) begin
            dout_m = cb;
            pd_m = 1;
         end else begin
            dout_m = q.pop_front();
         end
      end
      tick("chkbyte");
      for (int k = 0; k < 8 && !pd_m; k++) begin
         clr_in();
         laf = 1;
         if (q.size() > 0) dout_m = q.pop_front();
         if (q.size() == 0) pd_m = 1;
         tick("laf");
      end
      clr_in();
      rint = 1;
      lenv = (n > 63) ? 63 : n;
      e0_m = (cb != c0);
      e1_m = (cb != c1);
      le_m = (6'(lenv) != hdr[7:2]);
      lpv_m = 0;
      tick("rint");
      clr_in();
      tick("idle");
   endtask

   initial begin
      int n;
      logic [7:0] x, hdr, cb;
      logic [5:0] len;
      logic [1:0] ad;
      for (int i = 0; i < 16; i++) begin
         pay_b[i] = '0;
         ff_b[i] = 0;
      end
      clr_in();
      rst = 1;
      model_reset();
      tname = "reset";
      do_reset();
      do_reset();

      tname = "basic";
      pay_b[0] = 8'h11; pay_b[1] = 8'h22; pay_b[2] = 8'h33;
      send_pkt(8'h0D, 3, 8'h0D, 0);

      tname = "lenerr";
      send_pkt(8'h11, 3, 8'h0D, 0);

      tname = "badaddr";
      det_step(8'h0F);
      lfd_step();
      clr_in();
      tick("idle");

      tname = "midrst";
      det_step(8'h0D);
      lfd_step();
      ld_step(8'h5A, 1);
      ld_step(8'hA5, 1);
      clr_in();
      rst = 1;
      model_reset();
      tick("rst");
      rst = 0;
      clr_in();
      tick("idle");

      tname = "hold";
      pay_b[0] = 8'hA1; pay_b[1] = 8'hA2; pay_b[2] = 8'hA3;
      for (int i = 0; i < 3; i++) ff_b[i] = 1;
      send_pkt(8'h0D, 3, 8'h0D ^ 8'hA1 ^ 8'hA2 ^ 8'hA3, 1);

      tname = "ovf";
      for (int i = 0; i < 5; i++) begin
         pay_b[i] = 8'hB1 + 8'(i);
         ff_b[i] = 1;
      end
      send_pkt(8'h15, 5, 8'h00, 1);

      tname = "sum_ok";
      pay_b[0] = 8'hFF; ff_b[0] = 0;
      send_pkt(8'h05, 1, 8'h04, 0);
      tname = "sum_bad";
      send_pkt(8'h05, 1, 8'h05 ^ 8'hFF, 0);

      tname = "rand";
      for (int p = 0; p < 40; p++) begin
         n = $urandom_range(1, 8);
         ad = 2'($urandom_range(0, 2));
         len = ($urandom_range(0, 1) == 1) ? 6'(n) : 6'($urandom_range(0, 63));
         hdr = {len, ad};
         x = hdr;
         for (int i = 0; i < n; i++) begin
            pay_b[i] = 8'($urandom);
            ff_b[i] = ($urandom_range(0, 2) == 0);
            x = x ^ pay_b[i];
         end
         cb = ($urandom_range(0, 1) == 1) ? x : 8'($urandom);
         send_pkt(hdr, n, cb, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
